// File: rtl/vga_fb_scheduler.sv
// vga_fb_scheduler: VGA pixel sequencing with display-priority sharing of a single-port frame buffer.
// Define VGA_FB_SYNC_CHECK_EN to add the sticky sync_err output (disp_addr nonzero at col=0,row=0).
module vga_fb_scheduler #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              pixel_pulse,
  input  logic [9:0]        col,
  input  logic [9:0]        row,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              addr_enable,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pixel_data,
  output logic              hsync,
  output logic              vsync,
  output logic              blank,
`ifdef VGA_FB_SYNC_CHECK_EN
  output logic              sync_err,
`endif
  output logic              frame_start
);
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  state_t state;
  logic visible, wr_go;
  logic pulse_q, vis_q, hs_q, vs_q, fs_q;
  assign visible = (col < 10'd640) && (row < 10'd480);
  assign addr_enable = pixel_pulse & visible;
  // WR never follows WR, so a request still high in its ack cycle is not written twice
  assign wr_go = wr_req && (state != WR);
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_re <= 1'b0;
      mem_we <= 1'b0;
      wr_ack <= 1'b0;
    end else begin
      state <= addr_enable ? RD : wr_go ? WR : IDLE;
      mem_re <= addr_enable;
      mem_we <= !addr_enable && wr_go;
      wr_ack <= !addr_enable && wr_go;
      if (addr_enable) begin
        mem_addr <= disp_addr;
      end else if (wr_go) begin
        mem_addr <= wr_addr;
        mem_wdata <= wr_data;
      end
    end
  end
  // Timing flags are captured on the pulse and released with the read data one clk later
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pulse_q <= 1'b0;
      vis_q <= 1'b0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      fs_q <= 1'b0;
      pixel_data <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      blank <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      pulse_q <= pixel_pulse;
      if (pixel_pulse) begin
        vis_q <= visible;
        hs_q <= !((col >= 10'd656) && (col <= 10'd751));
        vs_q <= !((row >= 10'd490) && (row <= 10'd491));
        fs_q <= (col == 10'd0) && (row == 10'd0);
      end
      frame_start <= pulse_q && fs_q;
      if (pulse_q) begin
        pixel_data <= vis_q ? mem_rdata : '0;
        hsync <= hs_q;
        vsync <= vs_q;
        blank <= !vis_q;
      end
    end
  end
`ifdef VGA_FB_SYNC_CHECK_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) sync_err <= 1'b0;
    else if (pixel_pulse && (col == 10'd0) && (row == 10'd0) && (disp_addr != '0)) sync_err <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_vga_fb_scheduler.sv
// tb_vga_fb_scheduler: randomized pixel/host traffic checked against a cycle-indexed reference model.
module tb_vga_fb_scheduler;
  localparam int DW = 8;
  localparam int AW = 19;
  logic clk = 1'b0;
  logic n_rst = 1'b1;
  logic pixel_pulse = 1'b0;
  logic wr_req = 1'b0;
  logic [9:0] col = '0;
  logic [9:0] row = '0;
  logic [AW-1:0] disp_addr = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] mem_rdata;
  logic addr_enable, wr_ack, mem_we, mem_re, hsync, vsync, blank, frame_start;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, pixel_data;
`ifdef VGA_FB_SYNC_CHECK_EN
  logic sync_err;
  logic e_se;
`endif
  typedef struct {
    int due;
    logic [DW-1:0] pix;
    logic hs, vs, bl, fs;
  } pend_t;
  pend_t pq[$];
  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int ack_cnt = 0;
  int n_req = 0;
  int n_ack = 0;
  int en_cnt = 0;
  int fs_cnt = 0;
  bit host_on = 1'b0;
  logic e_re, e_we, e_hs, e_vs, e_bl, e_fs;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_pix;

  vga_fb_scheduler #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .n_rst(n_rst), .pixel_pulse(pixel_pulse), .col(col), .row(row),
    .disp_addr(disp_addr), .addr_enable(addr_enable), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(wr_ack), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .pixel_data(pixel_data),
    .hsync(hsync), .vsync(vsync), .blank(blank),
`ifdef VGA_FB_SYNC_CHECK_EN
    .sync_err(sync_err),
`endif
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pix_of(input logic [AW-1:0] a);
    int unsigned v;
    v = 32'(a);
    return DW'(v * 37 + (v >> 8) + 1);
  endfunction

  assign mem_rdata = pix_of(mem_addr);

  function automatic logic [AW-1:0] addr_of(input int c, input int r);
    int a;
    a = (c < 640 && r < 480) ? r * 640 + c : (r < 479 ? (r + 1) * 640 : 0);
    return AW'(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, want, cyc);
    end
  endtask

  task automatic model_reset();
    e_re = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0; e_pix = '0;
    e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b1; e_fs = 1'b0;
`ifdef VGA_FB_SYNC_CHECK_EN
    e_se = 1'b0;
`endif
    pq.delete();
    ack_cnt = 0;
  endtask

  task automatic check_all();
    chk("mem_re", 32'(mem_re), 32'(e_re));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("wr_ack", 32'(wr_ack), 32'(e_we));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    chk("pixel_data", 32'(pixel_data), 32'(e_pix));
    chk("hsync", 32'(hsync), 32'(e_hs));
    chk("vsync", 32'(vsync), 32'(e_vs));
    chk("blank", 32'(blank), 32'(e_bl));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("re_we_excl", 32'(mem_re & mem_we), 32'd0);
`ifdef VGA_FB_SYNC_CHECK_EN
    chk("sync_err", 32'(sync_err), 32'(e_se));
`endif
  endtask

  task automatic do_reset();
    pixel_pulse = 1'b0;
    n_rst = 1'b0;
    #1;
    model_reset();
    chk("rst_addr_enable", 32'(addr_enable), 32'd0);
    check_all();
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  // One clk: drive at negedge, check combinational enable, then registered outputs after the edge
  task automatic step(input logic p, input int c, input int r, input logic [AW-1:0] a);
    logic vis, rd, wr;
    pend_t x;
    if (ack_cnt > 0) begin
      ack_cnt--;
      if (ack_cnt == 0) wr_req = 1'b0;
    end else if (host_on && !wr_req && $urandom_range(3) == 0) begin
      wr_req = 1'b1;
      wr_addr = AW'($urandom_range(307199));
      wr_data = DW'($urandom);
      n_req++;
    end
    pixel_pulse = p; col = 10'(c); row = 10'(r); disp_addr = a;
    vis = (c < 640) && (r < 480);
    #1;
    chk("addr_enable", 32'(addr_enable), 32'(p && vis));
    if (addr_enable) en_cnt++;
    rd = p && vis;
    wr = wr_req && !rd && !e_we;
    e_re = rd;
    e_we = wr;
    if (rd) e_addr = a;
    else if (wr) begin
      e_addr = wr_addr;
      e_wdata = wr_data;
    end
`ifdef VGA_FB_SYNC_CHECK_EN
    if (p && c == 0 && r == 0 && a != '0) e_se = 1'b1;
`endif
    if (p) begin
      x.due = cyc + 2;
      x.pix = vis ? pix_of(a) : '0;
      x.hs = !(c >= 656 && c <= 751);
      x.vs = !(r >= 490 && r <= 491);
      x.bl = !vis;
      x.fs = (c == 0) && (r == 0);
      pq.push_back(x);
    end
    @(posedge clk);
    cyc++;
    #1;
    e_fs = 1'b0;
    if (pq.size() != 0 && pq[0].due == cyc) begin
      x = pq.pop_front();
      e_pix = x.pix; e_hs = x.hs; e_vs = x.vs; e_bl = x.bl; e_fs = x.fs;
    end
    check_all();
    if (wr_ack) begin
      ack_cnt = 2;
      n_ack++;
    end
    if (frame_start) fs_cnt++;
    @(negedge clk);
  endtask

  task automatic run(input int c0, input int r0, input int n, input int gmin, input int gmax);
    int c, r, g;
    c = c0;
    r = r0;
    for (int i = 0; i < n; i++) begin
      step(1'b1, c, r, addr_of(c, r));
      g = $urandom_range(gmax, gmin);
      for (int k = 1; k < g; k++) step(1'b0, c, r, addr_of(c, r));
      c++;
      if (c == 800) begin
        c = 0;
        r = (r == 524) ? 0 : r + 1;
      end
    end
  endtask

  task automatic line(input int r, input int gmax);
    en_cnt = 0;
    run(0, r, 800, 2, gmax);
    chk("line_enables", 32'(en_cnt), (r < 480) ? 32'd640 : 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    do_reset();
    run(0, 0, 8, 2, 2);
    run(700, 10, 1, 2, 2);
    repeat (3) step(1'b0, 700, 10, '0);
    chk("hsync_col700", 32'(hsync), 32'd0);
    chk("blank_col700", 32'(blank), 32'd1);
    wr_addr = AW'(32'h00123);
    wr_data = 8'hA5;
    wr_req = 1'b1;
    n_req++;
    step(1'b0, 0, 500, '0);
    chk("wr_latency", 32'(wr_ack), 32'd1);
    chk("wr_addr_dir", 32'(mem_addr), 32'h00123);
    chk("wr_data_dir", 32'(mem_wdata), 32'hA5);
    repeat (4) step(1'b0, 0, 500, '0);
    host_on = 1'b1;
    line(5, 2);
    line(6, 4);
    line(479, 3);
    line(480, 3);
    for (int r = 488; r <= 493; r++) line(r, 2 + (r & 1));
    fs_cnt = 0;
    line(524, 3);
    run(0, 0, 6, 2, 3);
    repeat (3) step(1'b0, 6, 0, addr_of(6, 0));
    chk("frame_start_count", 32'(fs_cnt), 32'd1);
    host_on = 1'b0;
    repeat (6) step(1'b0, 0, 500, '0);
    run(100, 200, 4, 2, 2);
    if (!wr_req) begin
      wr_req = 1'b1;
      n_req++;
    end
    wr_addr = AW'(32'h4BEEF);
    wr_data = 8'h3C;
    do_reset();
    repeat (6) step(1'b0, 0, 500, '0);
    chk("req_ack_balance", 32'(n_ack), 32'(n_req));
`ifdef VGA_FB_SYNC_CHECK_EN
    step(1'b1, 0, 0, AW'(5));
    repeat (20) step(1'b0, 1, 0, '0);
    run(0, 0, 3, 2, 2);
    chk("sync_err_sticky", 32'(sync_err), 32'd1);
    do_reset();
    chk("sync_err_cleared", 32'(sync_err), 32'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
